// File: rtl/aes_mode_ctrl.sv
// Block-mode sequencer for the AES core: ECB/CBC/CFB/OFB chaining around a
// single core, with a per-block reset/start/done handshake and a RUN timeout.
module aes_mode_ctrl #(
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_load,
  input  logic [1:0]       cfg_mode,
  input  logic [127:0]     cfg_key,
  input  logic [127:0]     cfg_iv,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [127:0]     in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [127:0]     out_data,
  output logic             core_rst,
  output logic             core_start,
  output logic [127:0]     core_din,
  output logic [127:0]     core_key,
  input  logic [127:0]     core_dout,
  input  logic             core_done,
  output logic             busy,
  output logic             err,
  output logic [CNT_W-1:0] blk_count
);

  localparam int unsigned DW    = 128;
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);

  localparam logic [1:0] M_ECB = 2'b00;
  localparam logic [1:0] M_CBC = 2'b01;
  localparam logic [1:0] M_CFB = 2'b10;
  localparam logic [1:0] M_OFB = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_CRST, S_RUN, S_OUT} state_t;

  state_t           state_q, state_d;
  logic [1:0]       mode_q;
  logic [DW-1:0]    key_q, chain_q, pt_q, din_q, out_q;
  logic [TMO_W-1:0] tmo_q;
  logic [CNT_W-1:0] blk_q;
  logic             err_q;

  logic             accept, done_hit, tmo_hit;
  logic [DW-1:0]    din_sel, res_out, res_chain;

  // Next state, per-cycle events and mode-dependent datapath selects
  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    done_hit  = 1'b0;
    tmo_hit   = 1'b0;
    din_sel   = in_data;
    res_out   = core_dout;
    res_chain = chain_q;

    case (mode_q)
      M_ECB: begin
        din_sel   = in_data;
        res_out   = core_dout;
        res_chain = chain_q;
      end
      M_CBC: begin
        din_sel   = in_data ^ chain_q;
        res_out   = core_dout;
        res_chain = core_dout;
      end
      M_CFB: begin
        din_sel   = chain_q;
        res_out   = core_dout ^ pt_q;
        res_chain = core_dout ^ pt_q;
      end
      M_OFB: begin
        din_sel   = chain_q;
        res_out   = core_dout ^ pt_q;
        res_chain = core_dout;
      end
      default: ;
    endcase

    case (state_q)
      S_IDLE: begin
        // A config load in the same cycle blocks acceptance
        if (!cfg_load && in_valid) begin
          accept  = 1'b1;
          state_d = S_CRST;
        end
      end
      S_CRST: state_d = S_RUN;
      S_RUN: begin
        // Completion beats timeout when both land in the same cycle
        if (core_done) begin
          done_hit = 1'b1;
          state_d  = S_OUT;
        end else if (tmo_q == TMO_W'(TIMEOUT_CYC - 1)) begin
          tmo_hit = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_OUT: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Configuration, chaining and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q  <= '0;
      key_q   <= '0;
      chain_q <= '0;
      pt_q    <= '0;
      din_q   <= '0;
      out_q   <= '0;
      tmo_q   <= '0;
      blk_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      if (state_q == S_IDLE && cfg_load) begin
        mode_q  <= cfg_mode;
        key_q   <= cfg_key;
        chain_q <= cfg_iv;
        blk_q   <= '0;
        err_q   <= 1'b0;
      end
      if (accept) begin
        pt_q  <= in_data;
        din_q <= din_sel;
      end
      if (state_q == S_CRST) tmo_q <= '0;
      if (state_q == S_RUN)  tmo_q <= tmo_q + TMO_W'(1);
      if (done_hit) begin
        out_q   <= res_out;
        chain_q <= res_chain;
        blk_q   <= blk_q + CNT_W'(1);
      end
      if (tmo_hit) err_q <= 1'b1;
    end
  end

  // Output decode; core_rst is held low while rst is asserted
  assign in_ready   = (state_q == S_IDLE) && !cfg_load;
  assign out_valid  = (state_q == S_OUT);
  assign core_rst   = (state_q == S_CRST) && !rst;
  assign core_start = (state_q == S_RUN);
  assign busy       = (state_q != S_IDLE);
  assign core_din   = din_q;
  assign core_key   = key_q;
  assign out_data   = out_q;
  assign err        = err_q;
  assign blk_count  = blk_q;

endmodule

// File: tb/tb_aes_mode_ctrl.sv
// Directed bench for aes_mode_ctrl with an XOR core model (done 12 cycles after start).
module tb_aes_mode_ctrl;

  logic         clk = 1'b0;
  logic         rst;
  logic         cfg_load;
  logic [1:0]   cfg_mode;
  logic [127:0] cfg_key, cfg_iv;
  logic         in_valid, in_ready;
  logic [127:0] in_data;
  logic         out_valid, out_ready;
  logic [127:0] out_data;
  logic         core_rst, core_start;
  logic [127:0] core_din, core_key, core_dout;
  logic         core_done;
  logic         busy, err;
  logic [15:0]  blk_count;

  int n_cmp = 0;
  int n_mis = 0;

  always #5 clk = ~clk;

  aes_mode_ctrl #(.CNT_W(16), .TIMEOUT_CYC(64)) dut (
    .clk(clk), .rst(rst),
    .cfg_load(cfg_load), .cfg_mode(cfg_mode), .cfg_key(cfg_key), .cfg_iv(cfg_iv),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .core_rst(core_rst), .core_start(core_start), .core_din(core_din),
    .core_key(core_key), .core_dout(core_dout), .core_done(core_done),
    .busy(busy), .err(err), .blk_count(blk_count)
  );

  // Core model: done 12 cycles after start rises, sticky until core_rst
  logic        model_en = 1'b1;
  int unsigned mcnt = 0;
  logic        mdone = 1'b0;
  int          rst_pulses = 0;

  always @(posedge clk) begin
    if (core_rst) begin
      mcnt  <= 0;
      mdone <= 1'b0;
    end else if (core_start && model_en && !mdone) begin
      mcnt <= mcnt + 1;
      if (mcnt + 1 == 12) mdone <= 1'b1;
    end
  end

  always @(posedge clk) if (core_rst) rst_pulses <= rst_pulses + 1;

  assign core_done = mdone;
  assign core_dout = core_din ^ core_key;

  task automatic do_cfg(input logic [1:0] m, input logic [127:0] k, input logic [127:0] iv);
    @(negedge clk);
    cfg_load = 1'b1; cfg_mode = m; cfg_key = k; cfg_iv = iv;
    @(negedge clk);
    cfg_load = 1'b0;
  endtask

  // Sends one block; lat counts cycles from handshake to out_valid
  task automatic send(input logic [127:0] pt, output logic [127:0] din,
                      output logic [127:0] dout, output int lat, output logic crst);
    logic seen;
    @(negedge clk);
    in_valid = 1'b1; in_data = pt;
    @(negedge clk);
    in_valid = 1'b0;
    din  = core_din;
    crst = core_rst;
    seen = 1'b0;
    lat  = 1;
    for (int i = 0; i < 200; i++) begin
      if (out_valid) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
      lat++;
    end
    dout = out_data;
    if (!seen) begin
      $display("FAIL send_timeout: out_valid never rose, got 0 want 1");
      n_mis++;
    end
    n_cmp++;
  endtask

  task automatic test_reset();
    rst = 1'b1; cfg_load = 1'b0; cfg_mode = 2'b00; cfg_key = '0; cfg_iv = '0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin $display("FAIL reset_in_ready: got %b want 1", in_ready); n_mis++; end
    n_cmp++; if ({out_valid, busy, err, core_rst, core_start} !== 5'b0) begin
      $display("FAIL reset_flags: got %b want 00000", {out_valid, busy, err, core_rst, core_start}); n_mis++; end
    n_cmp++; if ({core_din, core_key, out_data} !== 384'h0) begin
      $display("FAIL reset_data: din %h key %h out %h want all 0", core_din, core_key, out_data); n_mis++; end
    n_cmp++; if (blk_count !== 16'd0) begin $display("FAIL reset_blk: got %0d want 0", blk_count); n_mis++; end
  endtask

  task automatic test_ecb();
    logic [127:0] din, dout; int lat; logic crst;
    do_cfg(2'b00, 128'h1, 128'h0);
    send(128'h2, din, dout, lat, crst);
    n_cmp++; if (crst !== 1'b1) begin $display("FAIL ecb_core_rst: got %b want 1", crst); n_mis++; end
    n_cmp++; if (din !== 128'h2) begin $display("FAIL ecb_din: got %h want 2", din); n_mis++; end
    n_cmp++; if (lat !== 15) begin $display("FAIL ecb_latency: got %0d want 15", lat); n_mis++; end
    n_cmp++; if (dout !== 128'h3) begin $display("FAIL ecb_out: got %h want 3", dout); n_mis++; end
    n_cmp++; if (blk_count !== 16'd1) begin $display("FAIL ecb_blk: got %0d want 1", blk_count); n_mis++; end
    n_cmp++; if (core_key !== 128'h1) begin $display("FAIL ecb_key: got %h want 1", core_key); n_mis++; end
    @(negedge clk);
    n_cmp++; if ({out_valid, in_ready} !== 2'b01) begin
      $display("FAIL ecb_after: got valid/ready %b want 01", {out_valid, in_ready}); n_mis++; end
  endtask

  task automatic test_chain(input logic [1:0] m, input logic [127:0] din1, input logic [127:0] o1,
                            input logic [127:0] din2, input logic [127:0] o2);
    logic [127:0] din, dout; int lat; logic crst;
    do_cfg(m, 128'h1, 128'h10);
    send(128'h2, din, dout, lat, crst);
    n_cmp++; if (din !== din1) begin $display("FAIL chain%0d_din1: got %h want %h", m, din, din1); n_mis++; end
    n_cmp++; if (dout !== o1) begin $display("FAIL chain%0d_out1: got %h want %h", m, dout, o1); n_mis++; end
    send(128'h3, din, dout, lat, crst);
    n_cmp++; if (din !== din2) begin $display("FAIL chain%0d_din2: got %h want %h", m, din, din2); n_mis++; end
    n_cmp++; if (dout !== o2) begin $display("FAIL chain%0d_out2: got %h want %h", m, dout, o2); n_mis++; end
    n_cmp++; if (blk_count !== 16'd2) begin $display("FAIL chain%0d_blk: got %0d want 2", m, blk_count); n_mis++; end
  endtask

  task automatic test_back_pressure();
    int p; logic seen;
    do_cfg(2'b00, 128'h1, 128'h0);
    out_ready = 1'b0;
    p = rst_pulses;
    @(negedge clk);
    in_valid = 1'b1; in_data = 128'h5;
    @(negedge clk);
    in_data = 128'h7;
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (out_valid) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    n_cmp++; if (seen !== 1'b1) begin $display("FAIL bp_valid_rise: got 0 want 1"); n_mis++; end
    for (int i = 0; i < 20; i++) begin
      n_cmp++; if ({out_valid, in_ready} !== 2'b10 || out_data !== 128'h4) begin
        $display("FAIL bp_hold%0d: valid/ready %b data %h want 10 / 4", i, {out_valid, in_ready}, out_data); n_mis++; end
      @(negedge clk);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0) begin $display("FAIL bp_release: got %b want 0", out_valid); n_mis++; end
    n_cmp++; if (rst_pulses !== p + 1) begin $display("FAIL bp_core_rst_count: got %0d want %0d", rst_pulses - p, 1); n_mis++; end
    n_cmp++; if (blk_count !== 16'd1) begin $display("FAIL bp_blk: got %0d want 1", blk_count); n_mis++; end
  endtask

  task automatic test_timeout();
    logic [127:0] din, dout; int lat; logic crst; int runs; logic saw_valid, ended;
    do_cfg(2'b01, 128'h1, 128'h10);
    send(128'h2, din, dout, lat, crst);
    model_en = 1'b0;
    @(negedge clk);
    in_valid = 1'b1; in_data = 128'h9;
    @(negedge clk);
    in_valid = 1'b0;
    runs = 0; saw_valid = 1'b0; ended = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (core_start) runs++;
      if (out_valid) saw_valid = 1'b1;
      if (!busy) begin ended = 1'b1; break; end
      @(negedge clk);
    end
    n_cmp++; if (ended !== 1'b1) begin $display("FAIL tmo_return: busy stuck, got 1 want 0"); n_mis++; end
    n_cmp++; if (runs !== 64) begin $display("FAIL tmo_run_cycles: got %0d want 64", runs); n_mis++; end
    n_cmp++; if (err !== 1'b1) begin $display("FAIL tmo_err: got %b want 1", err); n_mis++; end
    n_cmp++; if (saw_valid !== 1'b0) begin $display("FAIL tmo_no_out: got %b want 0", saw_valid); n_mis++; end
    n_cmp++; if (blk_count !== 16'd1) begin $display("FAIL tmo_blk: got %0d want 1", blk_count); n_mis++; end
    model_en = 1'b1;
    send(128'h3, din, dout, lat, crst);
    n_cmp++; if (din !== 128'h10) begin $display("FAIL tmo_chain_kept: got %h want 10", din); n_mis++; end
    n_cmp++; if (dout !== 128'h11) begin $display("FAIL tmo_next_out: got %h want 11", dout); n_mis++; end
    do_cfg(2'b00, 128'h1, 128'h0);
    n_cmp++; if (err !== 1'b0) begin $display("FAIL tmo_err_clear: got %b want 0", err); n_mis++; end
  endtask

  task automatic test_load_priority();
    logic [127:0] din, dout; int lat; logic crst;
    @(negedge clk);
    cfg_load = 1'b1; cfg_mode = 2'b01; cfg_key = 128'h1; cfg_iv = 128'h20;
    in_valid = 1'b1; in_data = 128'h55;
    #1;
    n_cmp++; if (in_ready !== 1'b0) begin $display("FAIL lp_in_ready: got %b want 0", in_ready); n_mis++; end
    @(negedge clk);
    cfg_load = 1'b0; in_valid = 1'b0;
    n_cmp++; if (busy !== 1'b0) begin $display("FAIL lp_not_accepted: busy got %b want 0", busy); n_mis++; end
    send(128'h0, din, dout, lat, crst);
    n_cmp++; if (din !== 128'h20) begin $display("FAIL lp_new_iv: got %h want 20", din); n_mis++; end
    n_cmp++; if (dout !== 128'h21) begin $display("FAIL lp_out: got %h want 21", dout); n_mis++; end
  endtask

  task automatic test_rst_mid();
    do_cfg(2'b00, 128'h1, 128'h0);
    @(negedge clk);
    in_valid = 1'b1; in_data = 128'h2;
    @(negedge clk);
    in_valid = 1'b0; rst = 1'b1;
    #1;
    n_cmp++; if (core_rst !== 1'b0) begin $display("FAIL rst_core_rst_low: got %b want 0", core_rst); n_mis++; end
    @(negedge clk);
    rst = 1'b0;
    do_cfg(2'b00, 128'h1, 128'h0);
    @(negedge clk);
    in_valid = 1'b1; in_data = 128'h2;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    n_cmp++; if (core_start !== 1'b1) begin $display("FAIL rst_in_run: core_start got %b want 1", core_start); n_mis++; end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_cmp++; if ({busy, out_valid, core_start, core_rst, err, in_ready} !== 6'b000001) begin
      $display("FAIL rst_mid_flags: got %b want 000001", {busy, out_valid, core_start, core_rst, err, in_ready}); n_mis++; end
    n_cmp++; if ({core_din, core_key, out_data} !== 384'h0 || blk_count !== 16'd0) begin
      $display("FAIL rst_mid_data: din %h key %h out %h blk %0d want 0", core_din, core_key, out_data, blk_count); n_mis++; end
  endtask

  initial begin
    test_reset();
    test_ecb();
    test_chain(2'b01, 128'h12, 128'h13, 128'h10, 128'h11);
    test_chain(2'b10, 128'h10, 128'h13, 128'h13, 128'h11);
    test_chain(2'b11, 128'h10, 128'h13, 128'h11, 128'h13);
    test_back_pressure();
    test_timeout();
    test_load_priority();
    test_rst_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/aes_mode_ctrl.md
Name: aes_mode_ctrl

Overview:
Block-mode sequencer for the 128-bit AES encryption core. It accepts plaintext blocks on a valid/ready stream and applies ECB, CBC, CFB or OFB chaining. It drives the core through a per-block reset, start and done sequence and returns ciphertext on a valid/ready stream. It sits between the image block streamer and the single AES core instance, and owns the key, IV and chaining register.

Parameters:
CNT_W, 16, width of the processed-block counter
TIMEOUT_CYC, 64, maximum RUN cycles to wait for core_done before aborting the block

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
cfg_load  in  1  load mode, key and iv; honoured only in IDLE
cfg_mode  in  2  00 ECB, 01 CBC, 10 CFB, 11 OFB
cfg_key  in  128  cipher key
cfg_iv  in  128  initial chaining value
in_valid  in  1  plaintext block valid
in_ready  out  1  controller can accept a block
in_data  in  128  plaintext block
out_valid  out  1  ciphertext block valid
out_ready  in  1  downstream accepts the block
out_data  out  128  ciphertext block
core_rst  out  1  one-cycle reset pulse to the AES core
core_start  out  1  start level to the core, held through RUN
core_din  out  128  registered core input block
core_key  out  128  registered key
core_dout  in  128  core output
core_done  in  1  core completion; sticky until core_rst
busy  out  1  high whenever state is not IDLE
err  out  1  sticky timeout flag
blk_count  out  CNT_W  blocks completed since the last cfg_load

Behaviour:
- Reset: clk and rst are one clock and a synchronous active-high reset. On rst the state goes to IDLE and every register and output clears to 0, including mode, key, chain, core_din, out_data, blk_count and err. core_rst is 0 during rst. After rst releases, in_ready = 1.
- States: IDLE, CRST, RUN, OUT.
- IDLE:
  - in_ready = !cfg_load.
  - If cfg_load: latch mode and key, set chain = cfg_iv, clear blk_count and err, stay in IDLE. cfg_load wins over a same-cycle in_valid, so that block is not accepted.
  - Else if in_valid: latch pt = in_data, then go to CRST.
  - core_din is set by mode: ECB pt; CBC pt^chain; CFB chain; OFB chain.
- CRST: core_rst = 1 for exactly one cycle, then go to RUN. Clear the timeout counter.
- RUN:
  - core_start = 1 and the timeout counter increments every cycle.
  - On core_done = 1: r = core_dout.
    - ECB: out_data = r.
    - CBC: out_data = r and chain = r.
    - CFB: out_data = r^pt and chain = r^pt.
    - OFB: out_data = r^pt and chain = r.
    - blk_count increments, wrapping modulo 2^CNT_W. Then go to OUT.
  - If the counter reaches TIMEOUT_CYC without core_done: set err = 1, go to IDLE, produce no output, leave chain and blk_count unchanged.
  - core_done takes priority over timeout in the same cycle.
- OUT: out_valid = 1 and out_data is held stable until out_ready. On the handshake cycle go to IDLE; out_valid is 0 next cycle. Back-pressure may last indefinitely.
- Latency: handshake at cycle T, core_rst at T+1, core_start from T+2. If core_done is first seen at cycle D, out_valid rises at D+1.
- in_ready and out_valid are never high in the same cycle. At most one block is in flight.
- Stability: cfg_* inputs change nothing outside IDLE. core_key always equals the latched key. core_din is stable from CRST through RUN.
- Reset mid-operation: rst in any state returns the block to IDLE with all outputs 0. The in-flight block is dropped, and the latched configuration must be reloaded.

Test Plan:
The bench core model returns core_dout = core_din ^ core_key with core_done 12 cycles after core_start rises; it clears on core_rst.
1. ECB: cfg key=128'h1, in_data=128'h2 -> core_din=128'h2, out_data=128'h3, out_valid at handshake+15, blk_count=1.
2. CBC: iv=128'h10, key=128'h1, plaintexts 128'h2 then 128'h3 -> core_din 128'h12 then 128'h10; out_data 128'h13 then 128'h11.
3. CFB/OFB with iv=128'h10, key=128'h1, plaintexts 2 then 3:
   - CFB -> out_data 128'h13, then (core_din=13) 128'h11.
   - OFB -> 128'h13, then (core_din=11) 128'h13.
4. Back-pressure: hold out_ready=0 for 20 cycles -> out_valid and out_data stay constant, in_ready=0, no second core_rst. Release -> one transfer.
5. Timeout: the model never asserts done -> err=1 after 64 RUN cycles, return to IDLE, no out_valid, blk_count unchanged. A subsequent cfg_load clears err.
6. Simultaneous cfg_load and in_valid in IDLE -> block not accepted and chain=new iv. rst asserted during RUN -> next cycle IDLE, all outputs 0, in_ready=1.
